// File: rtl/exec_seq_pkg.sv
// exec_seq_pkg: shared types and constants for the execution sequencer.
//   seq_state_t : FSM state encoding, also shown on the display (state_o)
//   HALT_OP     : opcode that stops execution without committing
//   OPC_MSB/LSB : opcode field position inside the 12-bit instruction
package exec_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    STEP = 3'd1,
    RUN  = 3'd2,
    HALT = 3'd3
  } seq_state_t;

  localparam logic [2:0] HALT_OP = 3'b110;
  localparam int         OPC_MSB = 11;
  localparam int         OPC_LSB = 9;

endpackage

// File: rtl/exec_seq_if.sv
// exec_seq_if: request/status bundle between the button front end and the
// execution sequencer.
//   step_pulse, run_pulse, pause_pulse : one-cycle request pulses
//   load_busy                          : level, external memory load active
//   instr                              : instruction addressed by the control unit
//   exec_en                            : one-cycle commit strobe to the control unit
//   running, halted, state_o, exec_count : display status
//
// Handshake: there is no valid/ready pair. A request pulse is consumed on the
// clock edge where it is high and is never held or queued; a pulse that the
// current state does not accept (or that arrives while load_busy=1) is dropped.
// exec_en is a fire-and-forget strobe: the receiver must commit on every cycle
// it is high, and it is never high on two consecutive cycles.
interface exec_seq_if #(
  parameter int CNT_W = 8
);
  logic             step_pulse;
  logic             run_pulse;
  logic             pause_pulse;
  logic             load_busy;
  logic [11:0]      instr;
  logic             exec_en;
  logic             running;
  logic             halted;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] exec_count;

  // Button/control side.
  modport master (
    output step_pulse, run_pulse, pause_pulse, load_busy, instr,
    input  exec_en, running, halted, state_o, exec_count
  );

  // Sequencer side.
  modport slave (
    input  step_pulse, run_pulse, pause_pulse, load_busy, instr,
    output exec_en, running, halted, state_o, exec_count
  );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: free-running divider producing a one-cycle tick every TICK_DIV
// clock cycles.
//   clk, reset : system clock, synchronous active-high reset
//   clr        : restart the count so the next tick is TICK_DIV cycles away
//   tick       : high while the count sits at TICK_DIV-1
module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int             W    = $clog2(TICK_DIV);
  localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: turns debounced step/run/pause pulses into single-cycle
// exec_en strobes on the system clock, stopping on a HALT opcode.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : exec_seq_if slave (requests in, strobe and status out)
// Parameters: TICK_DIV cycles per run-mode tick (>= 2), CNT_W count width.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  exec_seq_if.slave   bus
);

  seq_state_t       state_q, state_d;
  logic             strobe_d;
  logic             div_clr;
  logic             tick;
  logic [2:0]       opcode;
  logic             exec_en_q;
  logic             running_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic             unused_instr_bits;

  assign opcode            = bus.instr[OPC_MSB:OPC_LSB];
  assign unused_instr_bits = ^bus.instr[OPC_LSB-1:0];

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (div_clr),
    .tick  (tick)
  );

  // Next-state and strobe decision. Pause and load_busy take priority over a
  // coincident tick, so neither can let a strobe slip out.
  always_comb begin
    state_d  = state_q;
    strobe_d = 1'b0;
    div_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.load_busy) begin
          if (bus.run_pulse) begin
            state_d = RUN;
          end else if (bus.step_pulse) begin
            state_d = STEP;
          end
        end
      end

      STEP: begin
        if (bus.load_busy || bus.pause_pulse) begin
          state_d = IDLE;
        end else if (tick) begin
          if (opcode == HALT_OP) begin
            state_d = HALT;
          end else begin
            strobe_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      RUN: begin
        if (bus.load_busy || bus.pause_pulse) begin
          state_d = IDLE;
        end else if (tick) begin
          if (opcode == HALT_OP) begin
            state_d = HALT;
          end else begin
            strobe_d = 1'b1;
          end
        end
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Restart the divider on entry so the first tick is a full period away.
    div_clr = ((state_d == RUN)  && (state_q != RUN)) ||
              ((state_d == STEP) && (state_q != STEP));
  end

  // State and registered outputs. The counter follows the registered strobe,
  // so a new count is visible one cycle after exec_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      exec_en_q <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      exec_en_q <= strobe_d;
      running_q <= (state_d == RUN);
      halted_q  <= (state_d == HALT);
      if (exec_en_q && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.exec_en    = exec_en_q;
  assign bus.running    = running_q;
  assign bus.halted     = halted_q;
  assign bus.state_o    = state_q;
  assign bus.exec_count = cnt_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed bench for exec_sequencer with TICK_DIV=4, CNT_W=4.
// A cycle-level behavioural model (mode + entry cycle, ticks found by modular
// arithmetic) is compared against every output on every cycle; a strobe
// schedule queue and literal spot checks pin the model to hand-derived values.
module tb_exec_sequencer;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  exec_seq_if #(.CNT_W(CNT_W)) bus ();

  exec_sequencer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];   // cycles in which exec_en must be high

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Modes use the display codes: 0 idle, 1 step, 2 run, 3 halt.
  int m_mode  = 0;
  int m_entry = 0;
  int m_cnt   = 0;
  bit m_exec  = 1'b0;

  function automatic void model_advance();
    bit tick_now;
    if (reset) begin
      m_mode = 0;
      m_cnt  = 0;
      m_exec = 1'b0;
    end else begin
      if (m_exec && (m_cnt < CNT_MAX)) m_cnt++;
      tick_now = ((m_mode == 1) || (m_mode == 2)) &&
                 (((cyc - m_entry) % TICK_DIV) == (TICK_DIV - 1));
      m_exec = 1'b0;
      if (m_mode == 0) begin
        if (!bus.load_busy && (bus.run_pulse || bus.step_pulse)) begin
          m_mode  = bus.run_pulse ? 2 : 1;
          m_entry = cyc + 1;
        end
      end else if ((m_mode == 1) || (m_mode == 2)) begin
        if (bus.load_busy || bus.pause_pulse) begin
          m_mode = 0;
        end else if (tick_now) begin
          if (bus.instr[11:9] == 3'b110) begin
            m_mode = 3;
          end else begin
            m_exec = 1'b1;
            if (m_mode == 1) m_mode = 0;
          end
        end
      end
    end
  endfunction

  // Compare process: checks the current cycle, then advances the model using
  // the inputs that the next rising edge will sample.
  initial begin
    bit sched;
    forever begin
      @(negedge clk);
      chk("exec_en",    {31'b0, bus.exec_en}, {31'b0, m_exec});
      chk("running",    {31'b0, bus.running}, {31'b0, (m_mode == 2)});
      chk("halted",     {31'b0, bus.halted},  {31'b0, (m_mode == 3)});
      chk("state_o",    {29'b0, bus.state_o}, 32'(m_mode));
      chk("exec_count", {28'b0, bus.exec_count}, 32'(m_cnt));
      sched = (exp_q.size() > 0) && (exp_q[0] == cyc);
      if (sched) void'(exp_q.pop_front());
      if (sched || (bus.exec_en !== 1'b0))
        chk("strobe_schedule", {31'b0, bus.exec_en}, {31'b0, sched});
      model_advance();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    if (t > cyc) tick_cycles(t - cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick_cycles(1);
    reset = 1'b0;
  endtask

  task automatic pulse_step();
    bus.step_pulse = 1'b1;
    tick_cycles(1);
    bus.step_pulse = 1'b0;
  endtask

  task automatic pulse_run();
    bus.run_pulse = 1'b1;
    tick_cycles(1);
    bus.run_pulse = 1'b0;
  endtask

  task automatic pulse_pause();
    bus.pause_pulse = 1'b1;
    tick_cycles(1);
    bus.pause_pulse = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int c;
    int c2;
    reset           = 1'b1;
    bus.step_pulse  = 1'b0;
    bus.run_pulse   = 1'b0;
    bus.pause_pulse = 1'b0;
    bus.load_busy   = 1'b0;
    bus.instr       = 12'h000;
    tick_cycles(2);
    reset = 1'b0;
    chk("reset_state_o",    {29'b0, bus.state_o}, 32'd0);
    chk("reset_exec_count", {28'b0, bus.exec_count}, 32'd0);

    // Single step: strobe exactly TICK_DIV+1 cycles after the pulse.
    wait_until(10);
    c = cyc;
    exp_q.push_back(c + 5);
    pulse_step();
    tick_cycles(8);
    chk("step_count", {28'b0, bus.exec_count}, 32'd1);
    chk("step_state", {29'b0, bus.state_o}, 32'd0);

    // Continuous run: strobes at +5, +9, +13, +17, pause at +18.
    do_reset();
    bus.instr = 12'h200;
    c = cyc;
    exp_q.push_back(c + 5);
    exp_q.push_back(c + 9);
    exp_q.push_back(c + 13);
    exp_q.push_back(c + 17);
    pulse_run();
    wait_until(c + 18);
    pulse_pause();
    tick_cycles(3);
    chk("run_count", {28'b0, bus.exec_count}, 32'd4);
    chk("run_state", {29'b0, bus.state_o}, 32'd0);

    // HALT opcode before the second tick: no strobe, absorbing.
    do_reset();
    c = cyc;
    exp_q.push_back(c + 5);
    pulse_run();
    wait_until(c + 6);
    bus.instr = 12'hC00;
    wait_until(c + 12);
    chk("halt_flag",  {31'b0, bus.halted},  32'd1);
    chk("halt_state", {29'b0, bus.state_o}, 32'd3);
    chk("halt_count", {28'b0, bus.exec_count}, 32'd1);
    bus.instr = 12'h000;
    pulse_run();
    pulse_step();
    pulse_pause();
    tick_cycles(6);
    chk("halt_sticky", {29'b0, bus.state_o}, 32'd3);
    do_reset();
    chk("post_reset_halted",  {31'b0, bus.halted}, 32'd0);
    chk("post_reset_running", {31'b0, bus.running}, 32'd0);
    chk("post_reset_count",   {28'b0, bus.exec_count}, 32'd0);

    // Pause coincident with a tick wins; run beats step in the same cycle.
    bus.instr = 12'h000;
    c = cyc;
    exp_q.push_back(c + 5);
    pulse_run();
    wait_until(c + 8);
    pulse_pause();
    tick_cycles(4);
    chk("pause_tick_state", {29'b0, bus.state_o}, 32'd0);
    chk("pause_tick_count", {28'b0, bus.exec_count}, 32'd1);
    c2 = cyc;
    exp_q.push_back(c2 + 5);
    bus.step_pulse = 1'b1;
    bus.run_pulse  = 1'b1;
    tick_cycles(1);
    bus.step_pulse = 1'b0;
    bus.run_pulse  = 1'b0;
    chk("run_beats_step", {29'b0, bus.state_o}, 32'd2);
    wait_until(c2 + 6);
    pulse_pause();
    tick_cycles(2);

    // Saturation: 20 strobes into a 4-bit counter.
    do_reset();
    c = cyc;
    for (int k = 0; k < 20; k++) exp_q.push_back(c + 5 + 4 * k);
    pulse_run();
    wait_until(c + 83);
    pulse_pause();
    tick_cycles(2);
    chk("sat_count", {28'b0, bus.exec_count}, 32'hF);

    // load_busy in RUN drops to IDLE; step while busy is ignored.
    do_reset();
    c = cyc;
    exp_q.push_back(c + 5);
    pulse_run();
    wait_until(c + 6);
    bus.load_busy = 1'b1;
    tick_cycles(4);
    chk("busy_idle", {29'b0, bus.state_o}, 32'd0);
    pulse_step();
    wait_until(c + 16);
    bus.load_busy = 1'b0;
    tick_cycles(6);
    chk("busy_state", {29'b0, bus.state_o}, 32'd0);
    chk("busy_count", {28'b0, bus.exec_count}, 32'd1);

    // Reset sampled on the edge that would raise exec_en.
    do_reset();
    c = cyc;
    pulse_step();
    wait_until(c + 4);
    do_reset();
    chk("reset_kills_strobe", {31'b0, bus.exec_en}, 32'd0);
    chk("reset_kills_state",  {29'b0, bus.state_o}, 32'd0);
    tick_cycles(3);
    chk("reset_kills_count",  {28'b0, bus.exec_count}, 32'd0);

    chk("schedule_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Execution sequencer between the debounced button pulses and the processor control unit. Replaces the free-running slow clock with a single-cycle `exec_en` strobe on the fast system clock. Supports single-step, continuous run at a divided rate, pause, and automatic stop on a HALT opcode. Exposes state and an executed-instruction count for the display controller.

## Interface

Parameters:
- `TICK_DIV`, 100_000_000, system-clock cycles per run-mode tick; must be ≥2.
- `CNT_W`, 8, width of `exec_count`.

Ports:
- `clk` input 1: system clock, 100 MHz board clock.
- `reset` input 1: synchronous, active-high; one clock, all state cleared on the edge where it is sampled high.
- `step_pulse` input 1: one-cycle pulse; request a single instruction.
- `run_pulse` input 1: one-cycle pulse; start continuous execution.
- `pause_pulse` input 1: one-cycle pulse; stop continuous execution.
- `load_busy` input 1: level; instruction memory or register file external load in progress.
- `instr` input 12: instruction currently addressed by the control unit; opcode is `instr[11:9]`.
- `exec_en` output 1: one-cycle strobe; control unit and datapath commit exactly one instruction.
- `running` output 1: high in RUN.
- `halted` output 1: high in HALT.
- `state_o` output 3: encoded FSM state for the display.
- `exec_count` output CNT_W: number of `exec_en` strobes since reset; saturates at all-ones.

## Operation

- States: IDLE=0, STEP=1, RUN=2, HALT=3. Other codes are unused and recover to IDLE on the next cycle.
- Internal `tick` is a one-cycle pulse every `TICK_DIV` cycles from a free-running divider. The divider is cleared by reset and by any entry into RUN or STEP, so the first tick arrives exactly `TICK_DIV` cycles after entry.
- **IDLE:**
  - `run_pulse` → RUN.
  - else `step_pulse` → STEP. Run wins if both arrive in the same cycle.
  - Pulses are ignored while `load_busy`=1.
- **STEP:**
  - On `tick`, if the opcode is HALT_OP (3'b110) → HALT with no strobe.
  - Otherwise issue one `exec_en` and return to IDLE.
  - `pause_pulse` → IDLE with no strobe.
- **RUN:**
  - On each `tick`, a HALT_OP opcode → HALT with no strobe; otherwise issue `exec_en` and stay in RUN.
  - `pause_pulse` → IDLE. If `pause_pulse` and `tick` occur in the same cycle, pause wins and no strobe is issued.
- **HALT:** absorbing. Step, run and pause are ignored. Only `reset` leaves HALT.
- `load_busy`=1 in STEP or RUN → IDLE on the next edge with no strobe. The divider is not advanced meaningfully, since it is cleared on re-entry.
- `exec_count` increments on every cycle in which `exec_en`=1 and holds at 2^CNT_W−1.
- `reset` in any state, including the cycle a strobe would issue: the next state is IDLE and `exec_en` is 0.

## Timing

- Reset values: `exec_en`=0, `running`=0, `halted`=0, `state_o`=0, `exec_count`=0, divider=0.
- All outputs are registered.
- If `tick` is high in cycle T, `exec_en` is high in cycle T+1 only, and `exec_count` shows the new value in cycle T+2.
- The HALT decision uses `instr` sampled in cycle T.
- `running`, `halted` and `state_o` change in the cycle after the causing pulse.
- Step latency: `step_pulse` in cycle C → STEP at C+1 → `exec_en` at C+1+TICK_DIV.
- Run rate: exactly one strobe per `TICK_DIV` cycles; no jitter.
- `exec_en` is never high on two consecutive cycles, because TICK_DIV ≥ 2.

## Structure

- Package `exec_seq_pkg`:
  - `seq_state_t` enum (IDLE, STEP, RUN, HALT, 3-bit).
  - `HALT_OP`=3'b110.
  - `OPC_MSB`=11, `OPC_LSB`=9.
- Sub-module `tick_gen`:
  - Parameterised divider: `clk`, `reset`, `clr`, output `tick`.
  - Counter width is `$clog2(TICK_DIV)`.
  - `tick` is high when count = TICK_DIV−1, then wraps to 0.
- Top: FSM, output registers and saturating counter.

## Test plan

All scenarios use TICK_DIV=4, CNT_W=4.

- Step with `instr`=12'h000: `step_pulse` at cycle 10 → `exec_en` high only at cycle 15; state returns to 0; `exec_count`=1.
- Run with `instr`=12'h200: `run_pulse` at cycle 0 → strobes at cycles 5, 9, 13, 17; `pause_pulse` at cycle 18 → IDLE; `exec_count`=4.
- Set `instr`=12'hC00 (opcode 110) in RUN before a tick → no strobe; `halted`=1 and `state_o`=3. Later `run_pulse` and `step_pulse` cause no change; `reset` → all outputs 0.
- `pause_pulse` coincident with `tick` in RUN → no strobe, IDLE. `step_pulse` and `run_pulse` in the same cycle from IDLE → RUN.
- Saturation: run for 20 ticks → `exec_count` holds at 4'hF and strobes continue.
- `load_busy`=1 for 10 cycles in RUN → IDLE with no strobes. `step_pulse` while `load_busy`=1 is ignored. `reset` asserted in the strobe cycle → `exec_en`=0.
